// File: rtl/cmn_arb_pkg.sv
// Shared types and constants for the round-robin arbiter family.
package cmn_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cmn_rr_arb_mux4_if.sv
// Four-requester input channels plus the shared output channel of the arbiter.
interface cmn_rr_arb_mux4_if #(
    parameter int p_nbits = 32
);
    import cmn_arb_pkg::*;

    logic [NREQ-1:0]         in_val;
    logic [NREQ-1:0]         in_rdy;
    logic [NREQ*p_nbits-1:0] in_msg;
    logic [NREQ-1:0]         in_last;
    logic                    out_val;
    logic                    out_rdy;
    logic [p_nbits-1:0]      out_msg;
    logic                    out_last;
    logic [IDX_W-1:0]        out_src;

    modport master (
        output in_val, in_msg, in_last, out_rdy,
        input  in_rdy, out_val, out_msg, out_last, out_src
    );

    modport slave (
        input  in_val, in_msg, in_last, out_rdy,
        output in_rdy, out_val, out_msg, out_last, out_src
    );

endinterface

// File: rtl/cmn_Mux4.sv
// Library 4-input mux, width p_nbits.
module cmn_Mux4 #(
    parameter int p_nbits = 1
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    input  logic [1:0]         sel,
    output logic [p_nbits-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/cmn_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module cmn_rr_picker
    import cmn_arb_pkg::*;
(
    input  logic [IDX_W-1:0] ptr,
    input  logic [NREQ-1:0]  req,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    logic [IDX_W-1:0] w_idx;

    // Scan from farthest to nearest so the closest requester to ptr is written last.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ptr + IDX_W'(k);
            if (req[w_idx]) begin
                grant   = w_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmn_rr_arb_mux4.sv
// Four-way round-robin arbiter with optional packet lock and a one-entry output register.
module cmn_rr_arb_mux4
    import cmn_arb_pkg::*;
#(
    parameter int p_nbits = 32,
    parameter bit p_lock  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    cmn_rr_arb_mux4_if.slave bus
);

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, r_lk, w_pick, w_g;
    logic               w_any, w_gv, w_en, w_xfer, w_last;
    logic [p_nbits:0]   w_beat;
    logic               r_out_val, r_out_last;
    logic [p_nbits-1:0] r_out_msg;
    logic [IDX_W-1:0]   r_out_src;

    cmn_rr_picker u_picker (
        .ptr     (r_ptr),
        .req     (bus.in_val),
        .grant   (w_pick),
        .any_req (w_any)
    );

    cmn_Mux4 #(.p_nbits(p_nbits + 1)) u_mux (
        .in0 ({bus.in_last[0], bus.in_msg[0*p_nbits +: p_nbits]}),
        .in1 ({bus.in_last[1], bus.in_msg[1*p_nbits +: p_nbits]}),
        .in2 ({bus.in_last[2], bus.in_msg[2*p_nbits +: p_nbits]}),
        .in3 ({bus.in_last[3], bus.in_msg[3*p_nbits +: p_nbits]}),
        .sel (w_g),
        .out (w_beat)
    );

    // The output register refills in the same cycle it drains.
    assign w_en   = !r_out_val || bus.out_rdy;
    assign w_g    = (r_state == LOCKED) ? r_lk : w_pick;
    assign w_gv   = (r_state == LOCKED) ? bus.in_val[r_lk] : w_any;
    assign w_xfer = w_gv && w_en && !reset;
    assign w_last = w_beat[p_nbits];

    assign bus.in_rdy = w_xfer ? idx_onehot(w_g) : '0;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (p_lock && w_xfer && !w_last) w_state_nxt = LOCKED;
            LOCKED:  if (w_xfer && w_last)            w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_lk  <= '0;
        end else if (w_xfer) begin
            if (r_state == IDLE && w_state_nxt == LOCKED) r_lk <= w_g;
            if (w_last || !p_lock)                        r_ptr <= w_g + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_val  <= 1'b0;
            r_out_msg  <= '0;
            r_out_last <= 1'b0;
            r_out_src  <= '0;
        end else if (w_xfer) begin
            r_out_val  <= 1'b1;
            r_out_msg  <= w_beat[p_nbits-1:0];
            r_out_last <= w_last;
            r_out_src  <= w_g;
        end else if (r_out_val && bus.out_rdy) begin
            r_out_val  <= 1'b0;
        end
    end

    assign bus.out_val  = r_out_val;
    assign bus.out_msg  = r_out_msg;
    assign bus.out_last = r_out_last;
    assign bus.out_src  = r_out_src;

endmodule

// File: tb/tb_cmn_rr_arb_mux4.sv
// Bench for cmn_rr_arb_mux4: a locking and a non-locking instance share stimulus.
module tb_cmn_rr_arb_mux4;

    logic        clk;
    logic        reset;
    logic [3:0]  in_val;
    logic [3:0]  in_last;
    logic [31:0] in_msg;
    logic        out_rdy;

    int checks = 0;
    int errors = 0;

    cmn_rr_arb_mux4_if #(.p_nbits(8)) bus0 ();
    cmn_rr_arb_mux4_if #(.p_nbits(8)) bus1 ();

    assign bus0.in_val  = in_val;
    assign bus0.in_last = in_last;
    assign bus0.in_msg  = in_msg;
    assign bus0.out_rdy = out_rdy;
    assign bus1.in_val  = in_val;
    assign bus1.in_last = in_last;
    assign bus1.in_msg  = in_msg;
    assign bus1.out_rdy = out_rdy;

    cmn_rr_arb_mux4 #(.p_nbits(8), .p_lock(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    cmn_rr_arb_mux4 #(.p_nbits(8), .p_lock(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [3:0] d_rdy  [2];
    logic       d_ov   [2];
    logic [7:0] d_msg  [2];
    logic       d_last [2];
    logic [1:0] d_src  [2];

    assign d_rdy[0]  = bus0.in_rdy;   assign d_rdy[1]  = bus1.in_rdy;
    assign d_ov[0]   = bus0.out_val;  assign d_ov[1]   = bus1.out_val;
    assign d_msg[0]  = bus0.out_msg;  assign d_msg[1]  = bus1.out_msg;
    assign d_last[0] = bus0.out_last; assign d_last[1] = bus1.out_last;
    assign d_src[0]  = bus0.out_src;  assign d_src[1]  = bus1.out_src;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model; instance 0 locks packets, instance 1 arbitrates every beat.
    int   m_ptr    [2];
    int   m_lk     [2];
    bit   m_locked [2];
    bit   m_ov     [2];
    int   m_msg    [2];
    bit   m_last   [2];
    int   m_src    [2];
    bit   m_init = 1'b0;

    function automatic int grant_of(input int d);
        if (m_locked[d]) return in_val[m_lk[d]] ? m_lk[d] : -1;
        for (int k = 0; k < 4; k++) begin
            if (in_val[(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
        end
        return -1;
    endfunction

    function automatic int exp_rdy(input int d);
        int g;
        g = grant_of(d);
        if (reset || g < 0 || (m_ov[d] && !out_rdy)) return 0;
        return 1 << g;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_ptr[d] = 0; m_lk[d] = 0; m_locked[d] = 0;
                m_ov[d] = 0; m_msg[d] = 0; m_last[d] = 0; m_src[d] = 0;
            end else begin
                int g;
                bit acc;
                bit lst;
                g   = grant_of(d);
                acc = (g >= 0) && (!m_ov[d] || out_rdy);
                if (acc) begin
                    lst       = in_last[g];
                    m_ov[d]   = 1;
                    m_msg[d]  = int'(in_msg[g*8 +: 8]);
                    m_last[d] = lst;
                    m_src[d]  = g;
                    if (d == 0) begin
                        if (!m_locked[d] && !lst) begin
                            m_locked[d] = 1; m_lk[d] = g;
                        end else if (m_locked[d] && lst) begin
                            m_locked[d] = 0;
                        end
                    end
                    if (lst || d == 1) m_ptr[d] = (g + 1) % 4;
                end else if (m_ov[d] && out_rdy) begin
                    m_ov[d] = 0;
                end
            end
        end
        if (reset) m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_rdy%0d", d),  int'(d_rdy[d]),  exp_rdy(d));
                chk($sformatf("model_oval%0d", d), int'(d_ov[d]),   int'(m_ov[d]));
                chk($sformatf("model_msg%0d", d),  int'(d_msg[d]),  m_msg[d]);
                chk($sformatf("model_last%0d", d), int'(d_last[d]), int'(m_last[d]));
                chk($sformatf("model_src%0d", d),  int'(d_src[d]),  m_src[d]);
            end
        end
    end

    task automatic set_in(input logic [3:0] v, input logic [3:0] l,
                          input logic [7:0] m3, input logic [7:0] m2,
                          input logic [7:0] m1, input logic [7:0] m0, input logic rdy);
        in_val  = v;
        in_last = l;
        in_msg  = {m3, m2, m1, m0};
        out_rdy = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t1_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1;
        set_in(4'b1111, 4'b1111, 8'h13, 8'h12, 8'h11, 8'h10, 1'b1);
        tick(); tick();
        chk("rst_oval", int'(d_ov[0]), 0);
        chk("rst_rdy",  int'(d_rdy[0]), 0);
        chk("rst_msg",  int'(d_msg[0]), 0);
        chk("rst_src",  int'(d_src[0]), 0);

        // All four requesters, single-beat packets.
        reset = 1'b0;
        #1 chk("t1_rdy_first", int'(d_rdy[0]), 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t1_src",  int'(d_src[0]), t1_exp[k]);
            chk("t1_oval", int'(d_ov[0]), 1);
        end

        // Three-beat packet from requester 2 with requester 0 waiting.
        set_in(4'b0101, 4'b0001, 8'h00, 8'hA0, 8'h00, 8'h10, 1'b1);
        tick();
        chk("t2_src_a0", int'(d_src[0]), 2);
        chk("t2_msg_a0", int'(d_msg[0]), 8'hA0);
        chk("t2_last_a0", int'(d_last[0]), 0);
        set_in(4'b0001, 4'b0001, 8'h00, 8'hA1, 8'h00, 8'h10, 1'b1);
        #1 chk("t2_drop_rdy", int'(d_rdy[0]), 0);
        tick();
        chk("t2_drop_oval", int'(d_ov[0]), 0);
        set_in(4'b0101, 4'b0001, 8'h00, 8'hA1, 8'h00, 8'h10, 1'b1);
        tick();
        chk("t2_src_a1", int'(d_src[0]), 2);
        chk("t2_msg_a1", int'(d_msg[0]), 8'hA1);
        set_in(4'b0101, 4'b0101, 8'h00, 8'hA2, 8'h00, 8'h10, 1'b1);
        tick();
        chk("t2_msg_a2",  int'(d_msg[0]), 8'hA2);
        chk("t2_last_a2", int'(d_last[0]), 1);
        tick();
        chk("t2_src_after", int'(d_src[0]), 0);
        chk("t2_msg_after", int'(d_msg[0]), 8'h10);

        // Backpressure then release.
        set_in(4'b0001, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h33, 1'b0);
        #1 chk("t3_bp_rdy", int'(d_rdy[0]), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_bp_msg",  int'(d_msg[0]), 8'h10);
            chk("t3_bp_oval", int'(d_ov[0]), 1);
            chk("t3_bp_rdy2", int'(d_rdy[0]), 0);
        end
        out_rdy = 1'b1;
        #1 chk("t3_rel_rdy", int'(d_rdy[0]), 4'b0001);
        tick();
        chk("t3_rel_msg",  int'(d_msg[0]), 8'h33);
        chk("t3_rel_oval", int'(d_ov[0]), 1);

        // Pointer wrap and a lone requester.
        set_in(4'b0100, 4'b0100, 8'h00, 8'h22, 8'h00, 8'h00, 1'b1);
        tick();
        chk("t4_src2", int'(d_src[0]), 2);
        set_in(4'b1001, 4'b1001, 8'h44, 8'h00, 8'h00, 8'h33, 1'b1);
        tick();
        chk("t4_src3", int'(d_src[0]), 3);
        chk("t4_msg3", int'(d_msg[0]), 8'h44);
        tick();
        chk("t4_src0", int'(d_src[0]), 0);
        set_in(4'b0010, 4'b0010, 8'h00, 8'h00, 8'h55, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_lone_src",  int'(d_src[0]), 1);
            chk("t4_lone_oval", int'(d_ov[0]), 1);
        end

        // Reset in the middle of a locked packet from requester 1.
        set_in(4'b0010, 4'b0000, 8'h00, 8'h00, 8'h66, 8'h00, 1'b1);
        tick();
        chk("t5_msg", int'(d_msg[0]), 8'h66);
        reset = 1'b1;
        #1 chk("t5_rst_rdy", int'(d_rdy[0]), 0);
        tick();
        chk("t5_rst_oval", int'(d_ov[0]), 0);
        set_in(4'b1111, 4'b1111, 8'h13, 8'h12, 8'h11, 8'h10, 1'b1);
        reset = 1'b0;
        #1 chk("t5_post_rdy", int'(d_rdy[0]), 4'b0001);
        tick();
        chk("t5_post_src", int'(d_src[0]), 0);

        // Non-locking instance alternates despite last=0 from requester 1.
        reset = 1'b1;
        set_in(4'b1010, 4'b1000, 8'h13, 8'h12, 8'h11, 8'h10, 1'b1);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_alt_src", int'(d_src[1]), (k % 2 == 0) ? 1 : 3);
        end

        set_in(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
